// File: rtl/switch_debounce_irq.sv
// rtl/switch_debounce_irq.sv - switch synchroniser, per-bit debouncer and change IRQ (IRQ logic under SWITCH_IRQ_EN)
module switch_debounce_irq #(
  parameter int WIDTH           = 8,
  parameter int CNT_BITS        = 20,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches_raw,
  output logic [WIDTH-1:0] switches_clean,
  output logic [WIDTH-1:0] change_mask,
  output logic             irq,
  input  logic             irq_ack
);

  // Terminal count: a new level must be seen on this many consecutive edges
  // (counting from zero) before it is accepted.
  localparam logic [CNT_BITS-1:0] LP_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] LP_ONE  = CNT_BITS'(1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_clean;
  logic [WIDTH-1:0] w_toggle;

  // Two-flop synchroniser per bit; nothing may sit between the stages.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= switches_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_level;
    logic                w_differs;
    logic                w_expire;

    // COUNTING while the synchronised pin disagrees with the accepted level.
    assign w_differs   = (r_sync2[g] != r_level);
    assign w_expire    = w_differs && (r_cnt == LP_LAST);
    assign w_toggle[g] = w_expire;
    assign w_clean[g]  = r_level;

    // Stability counter: any agreement restarts it, so short glitches never land.
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (!w_differs) begin
        r_cnt   <= '0;
      end else if (w_expire) begin
        r_cnt   <= '0;
        r_level <= r_sync2[g];
      end else begin
        r_cnt   <= r_cnt + LP_ONE;
      end
    end
  end

  assign switches_clean = w_clean;

`ifdef SWITCH_IRQ_EN
  logic [WIDTH-1:0] r_mask;

  // Sticky change flags; a toggle landing on the ack edge survives the clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mask <= '0;
    end else begin
      r_mask <= (irq_ack ? '0 : r_mask) | w_toggle;
    end
  end

  assign change_mask = r_mask;
  assign irq         = |r_mask;
`else
  logic [WIDTH:0] w_unused_irq_in;

  assign w_unused_irq_in = {irq_ack, w_toggle};
  assign change_mask     = '0;
  assign irq             = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce_irq.sv
// tb/tb_switch_debounce_irq.sv - randomized and directed bench for switch_debounce_irq against a window model
module tb_switch_debounce_irq;

  localparam int W = 8;
  localparam int D = 4;
`ifdef SWITCH_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] raw;
  logic         ack;
  logic [W-1:0] clean;
  logic [W-1:0] mask;
  logic         irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  switch_debounce_irq #(
    .WIDTH          (W),
    .CNT_BITS       (20),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .switches_raw  (raw),
    .switches_clean(clean),
    .change_mask   (mask),
    .irq           (irq),
    .irq_ack       (ack)
  );

  // Reference model: a bit is accepted once the last D synchronised samples
  // all show the opposite of the current clean level.
  logic [W-1:0] m_s1, m_s2, m_clean, m_mask;
  logic [D-1:0] m_win [W];
  logic [W-1:0] e_mask;
  logic         e_irq;

  always @(posedge clk) begin : model
    logic [W-1:0] tog;
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_mask = '0;
      for (int i = 0; i < W; i++) m_win[i] = '0;
    end else begin
      tog = '0;
      for (int i = 0; i < W; i++) begin
        m_win[i] = {m_win[i][D-2:0], m_s2[i]};
        if (m_win[i] == {D{~m_clean[i]}}) tog[i] = 1'b1;
      end
      m_clean = m_clean ^ tog;
      if (ack) m_mask = '0;
      m_mask = m_mask | tog;
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  always_comb begin
    e_mask = IRQ_ON ? m_mask : '0;
    e_irq  = |e_mask;
  end

  task automatic do_reset();
    reset = 1'b0; raw = '0; ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; raw = 8'hFF; ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (clean !== 8'h00 || mask !== 8'h00 || irq !== 1'b0) begin
        failures++;
        $display("FAIL reset cyc=%0d clean=%h mask=%h irq=%b exp=00/00/0", c, clean, mask, irq);
      end
    end
  endtask

  task automatic test_clean_step();
    logic [W-1:0] ec, em;
    do_reset();
    raw = 8'h01;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      ec = (e >= 6) ? 8'h01 : 8'h00;
      em = IRQ_ON ? ec : 8'h00;
      checks++;
      if (clean !== ec || mask !== em || irq !== (|em)) begin
        failures++;
        $display("FAIL clean_step edge=%0d clean=%h mask=%h irq=%b exp=%h/%h/%b", e, clean, mask, irq, ec, em, |em);
      end
    end
  endtask

  task automatic test_bounce();
    logic [W-1:0] ec, em;
    logic         prev;
    int           changes;
    do_reset();
    prev = 1'b0; changes = 0;
    for (int k = 0; k < 20; k++) begin
      raw = ((k / 2) % 2 == 0) ? 8'h08 : 8'h00;
      @(negedge clk);
      if (clean[3] !== prev) changes++;
      prev = clean[3];
      checks++;
      if (clean !== 8'h00 || mask !== 8'h00) begin
        failures++;
        $display("FAIL bounce_hold k=%0d clean=%h mask=%h exp=00/00", k, clean, mask);
      end
    end
    raw = 8'h08;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (clean[3] !== prev) changes++;
      prev = clean[3];
      ec = (e >= 6) ? 8'h08 : 8'h00;
      em = IRQ_ON ? ec : 8'h00;
      checks++;
      if (clean !== ec || mask !== em) begin
        failures++;
        $display("FAIL bounce_settle edge=%0d clean=%h mask=%h exp=%h/%h", e, clean, mask, ec, em);
      end
    end
    checks++;
    if (changes != 1) begin
      failures++;
      $display("FAIL bounce_changes got=%0d exp=1", changes);
    end
  endtask

  task automatic test_ack_race();
    logic [W-1:0] em;
    do_reset();
    raw = 8'h01;
    repeat (6) @(negedge clk);
    em = IRQ_ON ? 8'h01 : 8'h00;
    checks++;
    if (clean !== 8'h01 || mask !== em) begin
      failures++;
      $display("FAIL ack_pending clean=%h mask=%h exp=01/%h", clean, mask, em);
    end
    raw = 8'h21;
    for (int e = 1; e <= 6; e++) begin
      ack = (e == 6);
      @(negedge clk);
    end
    ack = 1'b0;
    em = IRQ_ON ? 8'h20 : 8'h00;
    checks++;
    if (clean !== 8'h21 || mask !== em || irq !== (|em)) begin
      failures++;
      $display("FAIL ack_race clean=%h mask=%h irq=%b exp=21/%h/%b", clean, mask, irq, em, |em);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if (clean !== 8'h21 || mask !== 8'h00 || irq !== 1'b0) begin
      failures++;
      $display("FAIL ack_second clean=%h mask=%h irq=%b exp=21/00/0", clean, mask, irq);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] ec, em;
    do_reset();
    raw = 8'h80;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (clean !== 8'h00 || mask !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_edge4 clean=%h mask=%h exp=00/00", clean, mask);
    end
    for (int e = 5; e <= 12; e++) begin
      @(negedge clk);
      ec = (e >= 10) ? 8'h80 : 8'h00;
      em = IRQ_ON ? ec : 8'h00;
      checks++;
      if (clean !== ec || mask !== em) begin
        failures++;
        $display("FAIL reset_mid edge=%0d clean=%h mask=%h exp=%h/%h", e, clean, mask, ec, em);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    hold = 0;
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        raw  = raw ^ W'($urandom_range(0, 255));
        hold = $urandom_range(1, 8);
      end
      hold--;
      ack   = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 199) != 0);
      @(negedge clk);
      checks++;
      if (clean !== m_clean || mask !== e_mask || irq !== e_irq) begin
        failures++;
        $display("FAIL random cyc=%0d clean=%h mask=%h irq=%b exp=%h/%h/%b", c, clean, mask, irq, m_clean, e_mask, e_irq);
      end
    end
    reset = 1'b1; ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; raw = '0; ack = 1'b0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_ack_race();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
